// File: rtl/pip_window_mixer_if.sv
// Pixel-request, FIFO and window-control bundle between the VGA timing
// side, the main/PIP read FIFOs and the picture-in-picture mixer.
interface pip_window_mixer_if;
    // VGA controller request stream
    logic        iRequest;
    logic [9:0]  iCoord_X;
    logic [9:0]  iCoord_Y;
    // per-frame window control
    logic        iFrame_Start;
    logic [9:0]  iWin_X;
    logic [9:0]  iWin_Y;
    logic        iPip_En;
    // main image FIFO
    logic        oMain_Rd;
    logic [29:0] iMain_Data;
    // PIP image FIFO
    logic        oPip_Rd;
    logic [29:0] iPip_Data;
    logic        iPip_Empty;
    logic        oPip_Flush;
    // pixel back to the VGA controller
    logic [9:0]  oRed;
    logic [9:0]  oGreen;
    logic [9:0]  oBlue;
    logic        oUnderrun;

    // the mixer itself
    modport master (
        input  iRequest, iCoord_X, iCoord_Y,
        input  iFrame_Start, iWin_X, iWin_Y, iPip_En,
        input  iMain_Data, iPip_Data, iPip_Empty,
        output oMain_Rd, oPip_Rd, oPip_Flush,
        output oRed, oGreen, oBlue, oUnderrun
    );

    // the surrounding VGA controller / FIFOs
    modport slave (
        output iRequest, iCoord_X, iCoord_Y,
        output iFrame_Start, iWin_X, iWin_Y, iPip_En,
        output iMain_Data, iPip_Data, iPip_Empty,
        input  oMain_Rd, oPip_Rd, oPip_Flush,
        input  oRed, oGreen, oBlue, oUnderrun
    );
endinterface

// File: rtl/pip_window_mixer.sv
// Picture-in-picture mixer: answers each VGA pixel request one cycle later
// with a main-image pixel, a border pixel or a downscaled PIP pixel, and
// tracks PIP FIFO underrun with a per-frame resync.
module pip_window_mixer #(
    parameter int unsigned H_ACT      = 640,
    parameter int unsigned V_ACT      = 480,
    parameter int unsigned PIP_W      = 160,
    parameter int unsigned PIP_H      = 120,
    parameter int unsigned BORDER_W   = 2,
    parameter logic [29:0] BORDER_RGB = 30'h3FFFFFFF
) (
    input logic          iCLK,
    input logic          iRST,
    pip_window_mixer_if.master bus
);

    // window arithmetic is done one bit wider than the coordinates
    localparam int unsigned CW = 11;

    localparam logic [CW-1:0] WIN_X_MIN = CW'(BORDER_W);
    localparam logic [CW-1:0] WIN_X_MAX = CW'(H_ACT - PIP_W - BORDER_W);
    localparam logic [CW-1:0] WIN_Y_MIN = CW'(BORDER_W);
    localparam logic [CW-1:0] WIN_Y_MAX = CW'(V_ACT - PIP_H - BORDER_W);
    localparam logic [CW-1:0] PIP_W_C   = CW'(PIP_W);
    localparam logic [CW-1:0] PIP_H_C   = CW'(PIP_H);
    localparam logic [CW-1:0] BORDER_C  = CW'(BORDER_W);
    localparam logic [CW-1:0] OUTER_W_C = CW'(PIP_W + BORDER_W);
    localparam logic [CW-1:0] OUTER_H_C = CW'(PIP_H + BORDER_W);

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        ACTIVE     = 2'd1,
        STARVED    = 2'd2
    } state_t;

    // what the pixel mux shows in the cycle after a request
    typedef enum logic [1:0] {
        SEL_ZERO   = 2'd0,
        SEL_MAIN   = 2'd1,
        SEL_BORDER = 2'd2,
        SEL_PIP    = 2'd3
    } sel_t;

    state_t        state;
    sel_t          pixSel;
    logic          pipEnReg;
    logic [CW-1:0] winX0;
    logic [CW-1:0] winY0;
    logic          pipFlushReg;
    logic          underrunReg;

    logic [CW-1:0] reqWinX;
    logic [CW-1:0] reqWinY;
    logic [CW-1:0] clampX0;
    logic [CW-1:0] clampY0;
    logic          effEn;
    logic [CW-1:0] effX0;
    logic [CW-1:0] effY0;
    logic          effActive;
    logic [CW-1:0] coordX;
    logic [CW-1:0] coordY;
    logic          inWin;
    logic          inOuter;
    logic          isWin;
    logic          isBorder;
    logic          pipRdC;
    logic          starveC;
    logic [29:0]   pixel;

    // clamp the requested window so the border always stays on screen
    always_comb begin
        reqWinX = {1'b0, bus.iWin_X};
        reqWinY = {1'b0, bus.iWin_Y};
        clampX0 = reqWinX;
        clampY0 = reqWinY;
        if (reqWinX < WIN_X_MIN) begin
            clampX0 = WIN_X_MIN;
        end else if (reqWinX > WIN_X_MAX) begin
            clampX0 = WIN_X_MAX;
        end
        if (reqWinY < WIN_Y_MIN) begin
            clampY0 = WIN_Y_MIN;
        end else if (reqWinY > WIN_Y_MAX) begin
            clampY0 = WIN_Y_MAX;
        end
    end

    // a frame-start pulse takes effect in its own cycle, so a coincident request sees the new window
    always_comb begin
        effEn     = pipEnReg;
        effX0     = winX0;
        effY0     = winY0;
        effActive = (state == ACTIVE);
        if (bus.iFrame_Start) begin
            effEn     = bus.iPip_En;
            effX0     = clampX0;
            effY0     = clampY0;
            effActive = 1'b1;
        end
    end

    // classify the requested coordinate as window, border or main
    always_comb begin
        coordX   = {1'b0, bus.iCoord_X};
        coordY   = {1'b0, bus.iCoord_Y};
        inWin    = (coordX >= effX0) && (coordX < effX0 + PIP_W_C) &&
                   (coordY >= effY0) && (coordY < effY0 + PIP_H_C);
        inOuter  = (coordX + BORDER_C >= effX0) && (coordX < effX0 + OUTER_W_C) &&
                   (coordY + BORDER_C >= effY0) && (coordY < effY0 + OUTER_H_C);
        isWin    = effEn && inWin;
        isBorder = effEn && inOuter && !inWin;
        pipRdC   = bus.iRequest && isWin && effActive && !bus.iPip_Empty && !iRST;
        starveC  = bus.iRequest && isWin && effActive && bus.iPip_Empty;
    end

    // every request pops the main FIFO, even pixels hidden under the window
    assign bus.oMain_Rd = bus.iRequest & ~iRST;
    assign bus.oPip_Rd  = pipRdC;

    // shadow window registers, only updated at frame start
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            pipEnReg <= 1'b0;
            winX0    <= '0;
            winY0    <= '0;
        end else if (bus.iFrame_Start) begin
            pipEnReg <= bus.iPip_En;
            winX0    <= clampX0;
            winY0    <= clampY0;
        end
    end

    // PIP stream state: flush on (re)entry to ACTIVE, starve on underrun until next frame
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state       <= WAIT_FRAME;
            pipFlushReg <= 1'b0;
            underrunReg <= 1'b0;
        end else begin
            pipFlushReg <= 1'b0;
            if (bus.iFrame_Start) begin
                state <= ACTIVE;
                if (state != ACTIVE) begin
                    pipFlushReg <= 1'b1;
                end
            end
            if (starveC) begin
                state       <= STARVED;
                underrunReg <= 1'b1;
            end
        end
    end

    // remember which source the next-cycle pixel must come from
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            pixSel <= SEL_ZERO;
        end else if (!bus.iRequest) begin
            pixSel <= SEL_ZERO;
        end else if (isWin) begin
            pixSel <= pipRdC ? SEL_PIP : SEL_ZERO;
        end else if (isBorder) begin
            pixSel <= SEL_BORDER;
        end else begin
            pixSel <= SEL_MAIN;
        end
    end

    // FIFO data lands one cycle after the read, so the pixel mux follows the registered select
    always_comb begin
        pixel = '0;
        case (pixSel)
            SEL_MAIN:   pixel = bus.iMain_Data;
            SEL_BORDER: pixel = BORDER_RGB;
            SEL_PIP:    pixel = bus.iPip_Data;
            default:    pixel = '0;
        endcase
    end

    assign bus.oRed       = pixel[29:20];
    assign bus.oGreen     = pixel[19:10];
    assign bus.oBlue      = pixel[9:0];
    assign bus.oPip_Flush = pipFlushReg;
    assign bus.oUnderrun  = underrunReg;

endmodule

// File: tb/tb_pip_window_mixer.sv
// Bench for pip_window_mixer: directed scenarios plus randomized frames,
// checked every cycle against a geometric reference model.
module tb_pip_window_mixer;

    localparam logic [29:0] BRD = 30'h3FFFFFFF;

    logic iCLK = 1'b0;
    logic iRST;

    always #5 iCLK = ~iCLK;

    pip_window_mixer_if bus();

    pip_window_mixer dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus.master)
    );

    int checks = 0;
    int errors = 0;

    // reference model: phase 0 = waiting for frame, 1 = streaming PIP, 2 = starved
    int          mPhase;
    bit          mEn;
    int          mX0;
    int          mY0;
    bit          mUnder;
    logic [29:0] expPix;
    bit          expFlush;
    bit          expUnder;
    bit          pendMainRd;
    bit          pendPipRd;
    logic [29:0] pendMainVal;
    logic [29:0] pendPipVal;
    bit          forceMain;
    logic [29:0] forceMainVal;

    logic [29:0] lastPix;
    logic        lastPipRd;
    logic        lastMainRd;
    logic        lastFlush;
    logic        lastUnder;
    int          pipRdCnt;
    int          mainRdCnt;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int clampI(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // 0 = main, 1 = border, 2 = window
    function automatic int regionOf(input int x, input int y);
        if (!mEn) return 0;
        if (x >= mX0 && x < mX0 + 160 && y >= mY0 && y < mY0 + 120) return 2;
        if (x >= mX0 - 2 && x < mX0 + 162 && y >= mY0 - 2 && y < mY0 + 122) return 1;
        return 0;
    endfunction

    task automatic modelReset();
        mPhase     = 0;
        mEn        = 0;
        mX0        = 0;
        mY0        = 0;
        mUnder     = 0;
        expPix     = '0;
        expFlush   = 0;
        expUnder   = 0;
        pendMainRd = 0;
        pendPipRd  = 0;
    endtask

    // one pixel-clock cycle: present FIFO data, drive request, check, advance model
    task automatic step(input bit req, input int x, input int y, input bit fs, input bit empty);
        int rg;
        bit expMainRd;
        bit expPipRd;
        @(negedge iCLK);
        if (pendMainRd) bus.iMain_Data = pendMainVal;
        if (pendPipRd)  bus.iPip_Data  = pendPipVal;
        bus.iRequest     = req;
        bus.iCoord_X     = 10'(x);
        bus.iCoord_Y     = 10'(y);
        bus.iFrame_Start = fs;
        bus.iPip_Empty   = empty;
        #1;
        lastPix    = {bus.oRed, bus.oGreen, bus.oBlue};
        lastPipRd  = bus.oPip_Rd;
        lastMainRd = bus.oMain_Rd;
        lastFlush  = bus.oPip_Flush;
        lastUnder  = bus.oUnderrun;
        chk("pixel", 32'(lastPix), 32'(expPix));
        chk("pip_flush", 32'(lastFlush), 32'(expFlush));
        chk("underrun", 32'(lastUnder), 32'(expUnder));

        if (fs) begin
            expFlush = (mPhase != 1);
            mPhase   = 1;
            mEn      = bus.iPip_En;
            mX0      = clampI(int'(bus.iWin_X), 2, 478);
            mY0      = clampI(int'(bus.iWin_Y), 2, 358);
        end else begin
            expFlush = 0;
        end
        rg        = req ? regionOf(x, y) : -1;
        expMainRd = req;
        expPipRd  = (rg == 2) && (mPhase == 1) && !empty;
        if (rg == 2 && mPhase == 1 && empty) begin
            mPhase = 2;
            mUnder = 1;
        end
        expUnder = mUnder;
        chk("main_rd", 32'(lastMainRd), 32'(expMainRd));
        chk("pip_rd", 32'(lastPipRd), 32'(expPipRd));
        if (lastMainRd === 1'b1) mainRdCnt++;
        if (lastPipRd === 1'b1)  pipRdCnt++;

        pendMainRd  = expMainRd;
        pendMainVal = forceMain ? forceMainVal : 30'($urandom);
        if (req) forceMain = 0;
        pendPipRd   = expPipRd;
        pendPipVal  = 30'($urandom);
        case (rg)
            0:       expPix = pendMainVal;
            1:       expPix = BRD;
            2:       expPix = expPipRd ? pendPipVal : 30'h0;
            default: expPix = 30'h0;
        endcase
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic frameStart(input bit en, input int wx, input int wy);
        bus.iPip_En = en;
        bus.iWin_X  = 10'(wx);
        bus.iWin_Y  = 10'(wy);
        step(0, 0, 0, 1, 0);
        idle();
    endtask

    // assert reset in the middle of a served line and expect everything low at once
    task automatic midReset();
        @(negedge iCLK);
        bus.iRequest     = 1'b1;
        bus.iCoord_X     = 10'd20;
        bus.iCoord_Y     = 10'd20;
        bus.iFrame_Start = 1'b0;
        #1;
        iRST = 1'b1;
        #1;
        chk("rst_pixel", 32'({bus.oRed, bus.oGreen, bus.oBlue}), 32'h0);
        chk("rst_main_rd", 32'(bus.oMain_Rd), 32'h0);
        chk("rst_pip_rd", 32'(bus.oPip_Rd), 32'h0);
        chk("rst_underrun", 32'(bus.oUnderrun), 32'h0);
        chk("rst_flush", 32'(bus.oPip_Flush), 32'h0);
        modelReset();
        @(negedge iCLK);
        iRST         = 1'b0;
        bus.iRequest = 1'b0;
    endtask

    initial begin
        logic [29:0] pipv;
        int x;
        int y;
        int r;

        iRST             = 1'b1;
        bus.iRequest     = 1'b1;
        bus.iCoord_X     = '0;
        bus.iCoord_Y     = '0;
        bus.iFrame_Start = 1'b0;
        bus.iWin_X       = '0;
        bus.iWin_Y       = '0;
        bus.iPip_En      = 1'b0;
        bus.iMain_Data   = 30'h155;
        bus.iPip_Data    = 30'h2AA;
        bus.iPip_Empty   = 1'b0;
        forceMain        = 0;
        forceMainVal     = '0;
        pipRdCnt         = 0;
        mainRdCnt        = 0;
        modelReset();

        // reset state, with a request held to show the main strobe is gated
        repeat (2) @(negedge iCLK);
        #1;
        chk("reset_pixel", 32'({bus.oRed, bus.oGreen, bus.oBlue}), 32'h0);
        chk("reset_main_rd", 32'(bus.oMain_Rd), 32'h0);
        chk("reset_pip_rd", 32'(bus.oPip_Rd), 32'h0);
        chk("reset_flush", 32'(bus.oPip_Flush), 32'h0);
        chk("reset_underrun", 32'(bus.oUnderrun), 32'h0);
        @(negedge iCLK);
        iRST         = 1'b0;
        bus.iRequest = 1'b0;
        idle();

        // PIP disabled: plain main passthrough
        frameStart(0, 0, 0);
        chk("t1_first_flush", 32'(lastFlush), 32'h1);
        forceMain    = 1;
        forceMainVal = 30'h1;
        step(1, 5, 5, 0, 0);
        chk("t1_main_rd", 32'(lastMainRd), 32'h1);
        idle();
        chk("t1_pixel", 32'(lastPix), 32'h1);
        chk("t1_no_pip_rd", 32'(pipRdCnt), 32'h0);

        // window at (100,50): PIP, border edges and main beside it
        frameStart(1, 100, 50);
        step(1, 100, 50, 0, 0);
        chk("t2_pip_rd", 32'(lastPipRd), 32'h1);
        pipv = pendPipVal;
        step(1, 98, 50, 0, 0);
        chk("t2_pip_pixel", 32'(lastPix), 32'(pipv));
        forceMain    = 1;
        forceMainVal = 30'h2AAAAAAA;
        step(1, 97, 50, 0, 0);
        chk("t2_left_border", 32'(lastPix), 32'(BRD));
        step(1, 260, 50, 0, 0);
        chk("t2_main_pixel", 32'(lastPix), 32'h2AAAAAAA);
        idle();
        chk("t2_right_border", 32'(lastPix), 32'(BRD));

        // oversized request clamps to (478,2)
        frameStart(1, 600, 0);
        step(1, 478, 2, 0, 0);
        chk("t3_clamped_pip_rd", 32'(lastPipRd), 32'h1);
        step(1, 477, 2, 0, 0);
        chk("t3_left_no_pip_rd", 32'(lastPipRd), 32'h0);
        idle();
        chk("t3_border", 32'(lastPix), 32'(BRD));

        // underrun, starvation for the rest of the frame, resync at next frame
        frameStart(1, 100, 50);
        step(1, 100, 50, 0, 1);
        chk("t4_empty_no_rd", 32'(lastPipRd), 32'h0);
        step(1, 101, 50, 0, 0);
        chk("t4_starved_pixel", 32'(lastPix), 32'h0);
        chk("t4_underrun", 32'(lastUnder), 32'h1);
        chk("t4_starved_no_rd", 32'(lastPipRd), 32'h0);
        idle();
        frameStart(1, 100, 50);
        chk("t4_resync_flush", 32'(lastFlush), 32'h1);
        step(1, 101, 50, 0, 0);
        chk("t4_resumed_rd", 32'(lastPipRd), 32'h1);

        // window control changes mid-frame are ignored
        frameStart(1, 100, 50);
        chk("t5_no_flush_active", 32'(lastFlush), 32'h0);
        bus.iWin_X = 10'd300;
        step(1, 100, 50, 0, 0);
        chk("t5_old_window_rd", 32'(lastPipRd), 32'h1);
        step(1, 300, 50, 0, 0);
        chk("t5_new_window_no_rd", 32'(lastPipRd), 32'h0);
        idle();

        // scan the full window neighbourhood and count strobes
        frameStart(1, 200, 150);
        pipRdCnt  = 0;
        mainRdCnt = 0;
        for (int yy = 148; yy < 272; yy++) begin
            for (int xx = 197; xx < 363; xx++) begin
                step(1, xx, yy, 0, 0);
            end
        end
        idle();
        chk("t6_pip_rd_count", 32'(pipRdCnt), 32'd19200);
        chk("t6_main_rd_count", 32'(mainRdCnt), 32'd20584);
        step(1, 10, 10, 0, 0);
        midReset();
        idle();

        // randomized frames around random windows
        for (int f = 0; f < 25; f++) begin
            frameStart(bit'($urandom_range(0, 3) != 0),
                       int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            for (int k = 0; k < 300; k++) begin
                r = int'($urandom_range(0, 9));
                if (r == 0) begin
                    idle();
                end else begin
                    if (r < 7) begin
                        x = clampI(mX0 - 4 + int'($urandom_range(0, 168)), 0, 639);
                        y = clampI(mY0 - 4 + int'($urandom_range(0, 128)), 0, 479);
                    end else begin
                        x = int'($urandom_range(0, 639));
                        y = int'($urandom_range(0, 479));
                    end
                    step(1, x, y, bit'($urandom_range(0, 499) == 0),
                         bit'($urandom_range(0, 199) == 0));
                end
            end
            idle();
            if (f == 12) begin
                step(1, 30, 30, 0, 0);
                midReset();
            end
        end
        repeat (3) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
